corevx_mmu_lookup: RTL and testbench

- Sv32 translation front-end between the core's load/store/fetch address path and corevx_ptw.
- Holds a direct-mapped TLB and answers translation requests from it. On a miss it drives the PTW resolve handshake, fills the TLB from the result, and checks permissions.
- Returns a 22-bit physical page number or a page/access fault per request.

---
 rtl/corevx_mmu_pkg.sv | 38 +++
 rtl/corevx_tlb_array.sv | 53 +++++
 rtl/corevx_mmu_lookup.sv | 158 +++++++++++++++
 tb/tb_corevx_mmu_lookup.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_mmu_pkg.sv
// rtl/corevx_mmu_pkg.sv - shared encodings, FSM states and permission check for the Sv32 lookup front-end
package corevx_mmu_pkg;

    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } pte_bits_t;

    localparam logic [1:0] REQ_LOAD  = 2'b00;
    localparam logic [1:0] REQ_STORE = 2'b01;
    localparam logic [1:0] REQ_EXEC  = 2'b10;
    localparam logic [1:0] REQ_RSVD  = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOOKUP   = 2'd1;
    localparam logic [1:0] ST_PTW_REQ  = 2'd2;
    localparam logic [1:0] ST_PTW_WAIT = 2'd3;

    // Reserved request type is checked as a load.
    function automatic logic perm_fault(input pte_bits_t bits, input logic [1:0] rtype);
        logic f;
        f = !bits.v || !bits.a;
        case (rtype)
            REQ_STORE: f = f || !bits.w || !bits.d;
            REQ_EXEC:  f = f || !bits.x;
            REQ_LOAD,
            REQ_RSVD:  f = f || !bits.r;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/corevx_tlb_array.sv
// rtl/corevx_tlb_array.sv - direct-mapped TLB storage with combinational tag compare and flush-all
module corevx_tlb_array #(
    parameter int TLB_ENTRIES_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [19:0] lookup_vpn,
    output logic        hit,
    output logic [21:0] hit_ppn,
    output logic [7:0]  hit_bits,
    input  logic        wr_en,
    input  logic [19:0] wr_vpn,
    input  logic [21:0] wr_ppn,
    input  logic [7:0]  wr_bits
);
    localparam int ENTRIES = 1 << TLB_ENTRIES_W;
    localparam int TAG_W   = 20 - TLB_ENTRIES_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [21:0]        ppn_q  [ENTRIES];
    logic [7:0]         bits_q [ENTRIES];

    logic [TLB_ENTRIES_W-1:0] lk_idx;
    logic [TLB_ENTRIES_W-1:0] wr_idx;

    assign lk_idx   = lookup_vpn[TLB_ENTRIES_W-1:0];
    assign wr_idx   = wr_vpn[TLB_ENTRIES_W-1:0];
    assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_vpn[19:TLB_ENTRIES_W]);
    assign hit_ppn  = ppn_q[lk_idx];
    assign hit_bits = bits_q[lk_idx];

    // Flush wins over a same-cycle fill so the written entry ends invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_vpn[19:TLB_ENTRIES_W];
            ppn_q[wr_idx]  <= wr_ppn;
            bits_q[wr_idx] <= wr_bits;
        end
    end

endmodule

// File: rtl/corevx_mmu_lookup.sv
// rtl/corevx_mmu_lookup.sv - Sv32 TLB lookup and PTW front-end; COREVX_MMU_PERF_COUNTERS_EN adds hit/miss counters
module corevx_mmu_lookup
    import corevx_mmu_pkg::*;
#(
    parameter int TLB_ENTRIES_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_vpn,
    input  logic [1:0]  req_type,
    output logic        resp_valid,
    output logic [21:0] resp_ppn,
    output logic        resp_pagefault,
    output logic        resp_accessfault,
    input  logic        tlb_invalidate,
    input  logic        matp_mode,
    output logic        ptw_resolve_request,
    input  logic        ptw_resolve_ack,
    output logic [19:0] ptw_virtual_address,
    input  logic        ptw_resolve_done,
    input  logic        ptw_resolve_pagefault,
    input  logic        ptw_resolve_accessfault,
    input  logic [7:0]  ptw_access_bits,
    input  logic [21:0] ptw_physical_address
`ifdef COREVX_MMU_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);
    logic [1:0]  state_q;
    logic [19:0] vpn_q;
    logic [1:0]  type_q;
    logic        inval_pending_q;

    logic        tlb_hit;
    logic [21:0] tlb_ppn;
    logic [7:0]  tlb_bits;
    logic        fill_en;
    logic        walk_done;

    assign walk_done = (state_q == ST_PTW_WAIT) && ptw_resolve_done;
    assign fill_en   = walk_done && !ptw_resolve_accessfault && !ptw_resolve_pagefault
                       && !inval_pending_q;

    corevx_tlb_array #(
        .TLB_ENTRIES_W(TLB_ENTRIES_W)
    ) u_tlb (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (tlb_invalidate),
        .lookup_vpn (vpn_q),
        .hit        (tlb_hit),
        .hit_ppn    (tlb_ppn),
        .hit_bits   (tlb_bits),
        .wr_en      (fill_en),
        .wr_vpn     (vpn_q),
        .wr_ppn     (ptw_physical_address),
        .wr_bits    (ptw_access_bits)
    );

    always_comb begin
        req_ready           = (state_q == ST_IDLE);
        resp_valid          = 1'b0;
        resp_ppn            = '0;
        resp_pagefault      = 1'b0;
        resp_accessfault    = 1'b0;
        ptw_resolve_request = 1'b0;
        ptw_virtual_address = '0;
        case (state_q)
            ST_LOOKUP: begin
                if (!matp_mode) begin
                    resp_valid = 1'b1;
                    resp_ppn   = {2'b00, vpn_q};
                end else if (tlb_hit) begin
                    resp_valid = 1'b1;
                    if (perm_fault(pte_bits_t'(tlb_bits), type_q)) begin
                        resp_pagefault = 1'b1;
                    end else begin
                        resp_ppn = tlb_ppn;
                    end
                end
            end
            ST_PTW_REQ: begin
                ptw_resolve_request = 1'b1;
                ptw_virtual_address = vpn_q;
            end
            ST_PTW_WAIT: begin
                if (ptw_resolve_done) begin
                    resp_valid = 1'b1;
                    if (ptw_resolve_accessfault) begin
                        resp_accessfault = 1'b1;
                    end else if (ptw_resolve_pagefault
                                 || perm_fault(pte_bits_t'(ptw_access_bits), type_q)) begin
                        resp_pagefault = 1'b1;
                    end else begin
                        resp_ppn = ptw_physical_address;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vpn_q   <= '0;
            type_q  <= REQ_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        vpn_q   <= req_vpn;
                        type_q  <= req_type;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_q <= (!matp_mode || tlb_hit) ? ST_IDLE : ST_PTW_REQ;
                end
                ST_PTW_REQ: begin
                    if (ptw_resolve_ack) state_q <= ST_PTW_WAIT;
                end
                ST_PTW_WAIT: begin
                    if (ptw_resolve_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A flush seen during a walk makes that walk's result stale, so it must not be cached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inval_pending_q <= 1'b0;
        end else if (walk_done || state_q == ST_IDLE) begin
            inval_pending_q <= 1'b0;
        end else if (tlb_invalidate && (state_q == ST_PTW_REQ || state_q == ST_PTW_WAIT)) begin
            inval_pending_q <= 1'b1;
        end
    end

`ifdef COREVX_MMU_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state_q == ST_LOOKUP && matp_mode) begin
            if (tlb_hit) perf_hits <= perf_hits + 32'd1;
            else         perf_misses <= perf_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_corevx_mmu_lookup.sv
// tb/tb_corevx_mmu_lookup.sv - scoreboard bench for corevx_mmu_lookup with a behavioural PTW responder
module tb_corevx_mmu_lookup;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_vpn;
    logic [1:0]  req_type;
    logic        resp_valid;
    logic [21:0] resp_ppn;
    logic        resp_pagefault;
    logic        resp_accessfault;
    logic        tlb_invalidate;
    logic        matp_mode;
    logic        ptw_resolve_request;
    logic        ptw_resolve_ack;
    logic [19:0] ptw_virtual_address;
    logic        ptw_resolve_done;
    logic        ptw_resolve_pagefault;
    logic        ptw_resolve_accessfault;
    logic [7:0]  ptw_access_bits;
    logic [21:0] ptw_physical_address;
`ifdef COREVX_MMU_PERF_COUNTERS_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    always #5 clk = ~clk;

    corevx_mmu_lookup dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_vpn                 (req_vpn),
        .req_type                (req_type),
        .resp_valid              (resp_valid),
        .resp_ppn                (resp_ppn),
        .resp_pagefault          (resp_pagefault),
        .resp_accessfault        (resp_accessfault),
        .tlb_invalidate          (tlb_invalidate),
        .matp_mode               (matp_mode),
        .ptw_resolve_request     (ptw_resolve_request),
        .ptw_resolve_ack         (ptw_resolve_ack),
        .ptw_virtual_address     (ptw_virtual_address),
        .ptw_resolve_done        (ptw_resolve_done),
        .ptw_resolve_pagefault   (ptw_resolve_pagefault),
        .ptw_resolve_accessfault (ptw_resolve_accessfault),
        .ptw_access_bits         (ptw_access_bits),
        .ptw_physical_address    (ptw_physical_address)
`ifdef COREVX_MMU_PERF_COUNTERS_EN
        ,
        .perf_hits               (perf_hits),
        .perf_misses             (perf_misses)
`endif
    );

    typedef struct {
        logic [21:0] ppn;
        logic        pf;
        logic        af;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_count = 0;
    int          resp_cyc = 0;
    int          walks = 0;
    logic [19:0] cur_vpn = '0;

    logic [21:0] cfg_ppn = '0;
    logic [7:0]  cfg_bits = '0;
    logic        cfg_pf = 1'b0;
    logic        cfg_af = 1'b0;
    logic        cfg_inval = 1'b0;
    int          cfg_delay = 2;

    always @(posedge clk) cyc++;

    // Monitor: every response pops one expectation; idle cycles must show zeroed result fields.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got ppn=%h pf=%b af=%b with empty scoreboard",
                             resp_ppn, resp_pagefault, resp_accessfault);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (resp_ppn !== mon_e.ppn || resp_pagefault !== mon_e.pf
                        || resp_accessfault !== mon_e.af) begin
                        errors++;
                        $display("FAIL resp vpn=%h: got ppn=%h pf=%b af=%b, want ppn=%h pf=%b af=%b",
                                 cur_vpn, resp_ppn, resp_pagefault, resp_accessfault,
                                 mon_e.ppn, mon_e.pf, mon_e.af);
                    end
                end
                resp_count++;
                resp_cyc = cyc;
            end else if (resp_ppn != '0 || resp_pagefault || resp_accessfault) begin
                checks++;
                errors++;
                $display("FAIL idle_outputs: got ppn=%h pf=%b af=%b, want all zero",
                         resp_ppn, resp_pagefault, resp_accessfault);
            end
        end
    end

    // Behavioural PTW: ack, optional mid-walk invalidate, then done with configured result.
    initial begin
        ptw_resolve_ack         = 1'b0;
        ptw_resolve_done        = 1'b0;
        ptw_resolve_pagefault   = 1'b0;
        ptw_resolve_accessfault = 1'b0;
        ptw_access_bits         = '0;
        ptw_physical_address    = '0;
        tlb_invalidate          = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ptw_resolve_request) begin
                walks++;
                checks++;
                if (ptw_virtual_address !== cur_vpn) begin
                    errors++;
                    $display("FAIL ptw_vaddr: got %h, want %h", ptw_virtual_address, cur_vpn);
                end
                ptw_resolve_ack = 1'b1;
                @(posedge clk); #1;
                ptw_resolve_ack = 1'b0;
                if (cfg_inval) begin
                    tlb_invalidate = 1'b1;
                    @(posedge clk); #1;
                    tlb_invalidate = 1'b0;
                end
                repeat (cfg_delay) @(posedge clk);
                #1;
                ptw_resolve_done        = 1'b1;
                ptw_resolve_pagefault   = cfg_pf;
                ptw_resolve_accessfault = cfg_af;
                ptw_access_bits         = cfg_bits;
                ptw_physical_address    = cfg_ppn;
                @(posedge clk); #1;
                ptw_resolve_done        = 1'b0;
                ptw_resolve_pagefault   = 1'b0;
                ptw_resolve_accessfault = 1'b0;
                ptw_access_bits         = '0;
                ptw_physical_address    = '0;
            end
        end
    end

    task automatic set_ptw(input logic [21:0] ppn, input logic [7:0] bits,
                           input logic pf, input logic af, input logic inval);
        cfg_ppn   = ppn;
        cfg_bits  = bits;
        cfg_pf    = pf;
        cfg_af    = af;
        cfg_inval = inval;
    endtask

    // elat = 0 skips the latency check; ewalks is the number of PTW walks this request must cause.
    task automatic do_req(input logic [19:0] vpn, input logic [1:0] t, input logic [21:0] eppn,
                          input logic epf, input logic eaf, input int elat, input int ewalks);
        int w0;
        int r0;
        int acc;
        int n;
        exp_t e;
        cur_vpn = vpn;
        w0 = walks;
        r0 = resp_count;
        e.ppn = eppn;
        e.pf  = epf;
        e.af  = eaf;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_vpn   = vpn;
        req_type  = t;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc = cyc;
        n = 0;
        while (resp_count == r0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (resp_count == r0) begin
            errors++;
            $display("FAIL resp_timeout vpn=%h: got no response, want one within 200 cycles", vpn);
            exp_q.delete();
        end else if (elat > 0) begin
            checks++;
            if (resp_cyc - acc + 1 != elat) begin
                errors++;
                $display("FAIL latency vpn=%h: got %0d, want %0d", vpn, resp_cyc - acc + 1, elat);
            end
        end
        checks++;
        if (walks - w0 != ewalks) begin
            errors++;
            $display("FAIL walks vpn=%h: got %0d, want %0d", vpn, walks - w0, ewalks);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

`ifdef COREVX_MMU_PERF_COUNTERS_EN
    logic [31:0] hits0;
    logic [31:0] miss0;
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_vpn   = '0;
        req_type  = 2'b00;
        matp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ptw_resolve_request !== 1'b0
            || ptw_virtual_address !== '0 || resp_ppn !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b rv=%b preq=%b pva=%h ppn=%h, want 1 0 0 0 0",
                     req_ready, resp_valid, ptw_resolve_request, ptw_virtual_address, resp_ppn);
        end
        rst_n = 1'b1;

        // bare mode passthrough
        do_req(20'h12345, 2'b00, 22'h012345, 1'b0, 1'b0, 1, 0);

        matp_mode = 1'b1;
        set_ptw(22'h3ABCD, 8'hCF, 1'b0, 1'b0, 1'b0);
        do_req(20'h00401, 2'b00, 22'h3ABCD, 1'b0, 1'b0, 0, 1);
        do_req(20'h00401, 2'b00, 22'h3ABCD, 1'b0, 1'b0, 1, 0);

        // V R A only: store faults both on the walk and on the cached hit, load hits
        set_ptw(22'h11111, 8'h43, 1'b0, 1'b0, 1'b0);
        do_req(20'h00402, 2'b01, 22'h0, 1'b1, 1'b0, 0, 1);
        do_req(20'h00402, 2'b01, 22'h0, 1'b1, 1'b0, 1, 0);
        do_req(20'h00402, 2'b00, 22'h11111, 1'b0, 1'b0, 1, 0);

        set_ptw(22'h22222, 8'hC7, 1'b0, 1'b0, 1'b0);
        do_req(20'h00403, 2'b01, 22'h22222, 1'b0, 1'b0, 0, 1);
        do_req(20'h00403, 2'b10, 22'h0, 1'b1, 1'b0, 1, 0);

        // access fault dominates a simultaneous page fault and is not cached
        set_ptw(22'h0ABCD, 8'hCF, 1'b1, 1'b1, 1'b0);
        do_req(20'h00404, 2'b00, 22'h0, 1'b0, 1'b1, 0, 1);
        set_ptw(22'h0ABCD, 8'hCF, 1'b0, 1'b1, 1'b0);
        do_req(20'h00404, 2'b00, 22'h0, 1'b0, 1'b1, 0, 1);
        set_ptw(22'h0ABCE, 8'hCF, 1'b1, 1'b0, 1'b0);
        do_req(20'h00405, 2'b00, 22'h0, 1'b1, 1'b0, 0, 1);

        // invalidate mid-walk: response delivered, nothing cached, earlier entries flushed
        set_ptw(22'h33333, 8'hCF, 1'b0, 1'b0, 1'b1);
        do_req(20'h00406, 2'b00, 22'h33333, 1'b0, 1'b0, 0, 1);
        set_ptw(22'h33334, 8'hCF, 1'b0, 1'b0, 1'b0);
        do_req(20'h00406, 2'b00, 22'h33334, 1'b0, 1'b0, 0, 1);
        set_ptw(22'h3ABCD, 8'hCF, 1'b0, 1'b0, 1'b0);
        do_req(20'h00401, 2'b00, 22'h3ABCD, 1'b0, 1'b0, 0, 1);

`ifdef COREVX_MMU_PERF_COUNTERS_EN
        hits0 = perf_hits;
        miss0 = perf_misses;
`endif
        // aliasing vpns share index 0 and evict each other
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                set_ptw(22'h00100, 8'hCF, 1'b0, 1'b0, 1'b0);
                do_req(20'h00010, 2'b00, 22'h00100, 1'b0, 1'b0, 0, 1);
            end else begin
                set_ptw(22'h00200, 8'hCF, 1'b0, 1'b0, 1'b0);
                do_req(20'h00020, 2'b00, 22'h00200, 1'b0, 1'b0, 0, 1);
            end
        end
`ifdef COREVX_MMU_PERF_COUNTERS_EN
        checks++;
        if (perf_misses - miss0 != 32'd4 || perf_hits != hits0) begin
            errors++;
            $display("FAIL perf_alias: got misses+%0d hits+%0d, want misses+4 hits+0",
                     perf_misses - miss0, perf_hits - hits0);
        end
`endif

        // reserved type behaves as load; store hit on a fully permissive entry
        do_req(20'h00020, 2'b11, 22'h00200, 1'b0, 1'b0, 1, 0);
        do_req(20'h00020, 2'b01, 22'h00200, 1'b0, 1'b0, 1, 0);

        // bare mode ignores a valid cached entry
        matp_mode = 1'b0;
        do_req(20'h00020, 2'b00, 22'h000020, 1'b0, 1'b0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
